// File: rtl/uart_axil_pkg.sv
// Shared definitions for the UART AXI4-Lite register block: register map,
// response codes, FSM state encodings and register bit positions.
package uart_axil_pkg;

    // Byte offsets of the four registers (decode uses address bits [3:2])
    localparam logic [3:0] RX_DATA_OFF = 4'h0;
    localparam logic [3:0] TX_DATA_OFF = 4'h4;
    localparam logic [3:0] STATUS_OFF  = 4'h8;
    localparam logic [3:0] CONTROL_OFF = 4'hC;

    typedef logic [1:0] resp_t;
    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    // STATUS bits
    localparam int ST_RX_AVAIL = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_TX_DROP  = 2;

    // CONTROL bits
    localparam int CTL_EN_RX = 0;
    localparam int CTL_EN_TX = 1;

    // Offset of the register word an address selects
    function automatic logic [3:0] reg_off(input logic [1:0] word_sel);
        return {word_sel, 2'b00};
    endfunction

endpackage

// File: rtl/uart_axil_regs_if.sv
// AXI4-Lite bus bundle between software master and the UART register block.
interface uart_axil_regs_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/uart_axil_regs.sv
// AXI4-Lite slave in front of the UART core: turns bus writes into TX pushes
// and enables, bus reads into RX pops, and reports FIFO status to software.
//
// state  | meaning
// W_IDLE | collecting AW and W independently; acts once both are held
// W_RESP | register action done, bvalid held until bready
// R_IDLE | arready high, read value registered on AR handshake
// R_DATA | rvalid held with stable rdata until rready
module uart_axil_regs
    import uart_axil_pkg::*;
#(
    parameter int C_ADDR_WIDTH = 4,
    parameter int C_DATA_WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Resetn,
    uart_axil_regs_if.slave  s_axil,
    output logic [7:0]       TX_data,
    output logic             wr_uart_en,
    input  logic             Full,
    input  logic [7:0]       RX_data,
    input  logic             Empty,
    output logic             rd_uart_en,
    output logic             Enable_rx,
    output logic             Enable_tx
);

    // Address bits above the 16-byte window; any set bit is an error
    localparam logic [C_ADDR_WIDTH-1:0] HI_MASK = C_ADDR_WIDTH'(32'hFFFF_FFF0);

    wr_state_t               wr_state, wr_next;
    rd_state_t               rd_state, rd_next;
    logic                    ready_en;
    logic                    aw_held, w_held;
    logic [C_ADDR_WIDTH-1:0] awaddr_q;
    logic [7:0]              wbyte_q;
    logic                    wstrb0_q;
    logic                    tx_drop;
    resp_t                   bresp_q, rresp_q;
    logic [C_DATA_WIDTH-1:0] rdata_q, rd_value;
    logic                    awready, wready, bvalid, arready, rvalid;
    logic                    do_write, wr_err, drop_set, drop_clr, push;
    logic                    ar_hs, rd_err;
    logic [3:0]              wr_off, rd_off;

    assign s_axil.awready = awready;
    assign s_axil.wready  = wready;
    assign s_axil.bvalid  = bvalid;
    assign s_axil.bresp   = bresp_q;
    assign s_axil.arready = arready;
    assign s_axil.rvalid  = rvalid;
    assign s_axil.rresp   = rresp_q;
    assign s_axil.rdata   = rdata_q;

    assign wr_err   = |(awaddr_q & HI_MASK);
    assign wr_off   = reg_off(awaddr_q[3:2]);
    assign do_write = (wr_state == W_IDLE) && aw_held && w_held;
    assign push     = do_write && !wr_err && (wr_off == TX_DATA_OFF) && wstrb0_q && !Full;
    assign drop_set = do_write && !wr_err && (wr_off == TX_DATA_OFF) && wstrb0_q && Full;
    assign drop_clr = do_write && !wr_err && (wr_off == STATUS_OFF) && wstrb0_q && wbyte_q[ST_TX_DROP];

    assign ar_hs      = s_axil.arvalid && arready;
    assign rd_err     = |(s_axil.araddr & HI_MASK);
    assign rd_off     = reg_off(s_axil.araddr[3:2]);
    assign rd_uart_en = ar_hs && !rd_err && (rd_off == RX_DATA_OFF) && !Empty;

    // Keeps all ready signals low until the first clock after reset release
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) ready_en <= 1'b0;
        else         ready_en <= 1'b1;
    end

    // Write FSM state register
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) wr_state <= W_IDLE;
        else         wr_state <= wr_next;
    end

    // Write FSM next state and channel handshakes
    always_comb begin
        wr_next = wr_state;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (wr_state)
            W_IDLE: begin
                awready = ready_en && !aw_held;
                wready  = ready_en && !w_held;
                if (do_write) wr_next = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (s_axil.bready) wr_next = W_IDLE;
            end
            default: wr_next = W_IDLE;
        endcase
    end

    // AW and W capture; holds released when the response is accepted
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            awaddr_q <= '0;
            wbyte_q  <= '0;
            wstrb0_q <= 1'b0;
        end else if (wr_state == W_RESP && s_axil.bready) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
        end else begin
            if (s_axil.awvalid && awready) begin
                aw_held  <= 1'b1;
                awaddr_q <= s_axil.awaddr;
            end
            if (s_axil.wvalid && wready) begin
                w_held   <= 1'b1;
                wbyte_q  <= s_axil.wdata[7:0];
                wstrb0_q <= s_axil.wstrb[0];
            end
        end
    end

    // Register side effects of a completed write; push strobe lasts one cycle
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            bresp_q    <= RESP_OKAY;
            TX_data    <= '0;
            wr_uart_en <= 1'b0;
            Enable_rx  <= 1'b0;
            Enable_tx  <= 1'b0;
            tx_drop    <= 1'b0;
        end else begin
            wr_uart_en <= push;
            tx_drop    <= drop_set || (tx_drop && !drop_clr);
            if (push) TX_data <= wbyte_q;
            if (do_write) begin
                bresp_q <= wr_err ? RESP_SLVERR : RESP_OKAY;
                if (!wr_err && wr_off == CONTROL_OFF && wstrb0_q) begin
                    Enable_rx <= wbyte_q[CTL_EN_RX];
                    Enable_tx <= wbyte_q[CTL_EN_TX];
                end
            end
        end
    end

    // Read value mux; an empty RX register reads as zero
    always_comb begin
        rd_value = '0;
        if (!rd_err) begin
            case (rd_off)
                RX_DATA_OFF: if (!Empty) rd_value[8:0] = {1'b1, RX_data};
                STATUS_OFF: begin
                    rd_value[ST_RX_AVAIL] = !Empty;
                    rd_value[ST_TX_FULL]  = Full;
                    rd_value[ST_TX_DROP]  = tx_drop;
                end
                CONTROL_OFF: begin
                    rd_value[CTL_EN_RX] = Enable_rx;
                    rd_value[CTL_EN_TX] = Enable_tx;
                end
                default: rd_value = '0;
            endcase
        end
    end

    // Read FSM state register
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) rd_state <= R_IDLE;
        else         rd_state <= rd_next;
    end

    // Read FSM next state and channel handshakes
    always_comb begin
        rd_next = rd_state;
        arready = 1'b0;
        rvalid  = 1'b0;
        case (rd_state)
            R_IDLE: begin
                arready = ready_en;
                if (ar_hs) rd_next = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (s_axil.rready) rd_next = R_IDLE;
            end
            default: rd_next = R_IDLE;
        endcase
    end

    // Read data/response captured in the same cycle as the pop strobe
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ar_hs) begin
            rdata_q <= rd_value;
            rresp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
        end
    end

endmodule

// File: tb/tb_uart_axil_regs.sv
// Directed bench for uart_axil_regs: register map, TX push/drop, RX pop,
// concurrent read/write and reset in the middle of a write response.
module tb_uart_axil_regs;

    logic       Clk = 1'b0;
    logic       Resetn = 1'b1;
    logic       Full = 1'b0;
    logic       Empty = 1'b1;
    logic [7:0] RX_data = 8'h00;
    logic [7:0] TX_data;
    logic       wr_uart_en, rd_uart_en, Enable_rx, Enable_tx;

    int checks = 0;
    int passed = 0;
    int wr_cnt = 0, rd_cnt = 0, b_cnt = 0, r_cnt = 0;
    logic [7:0] tx_last = 8'h00;

    always #5 Clk = ~Clk;

    uart_axil_regs_if #(.ADDR_W(4)) bus();

    uart_axil_regs #(.C_ADDR_WIDTH(4), .C_DATA_WIDTH(32)) dut (
        .Clk        (Clk),
        .Resetn     (Resetn),
        .s_axil     (bus),
        .TX_data    (TX_data),
        .wr_uart_en (wr_uart_en),
        .Full       (Full),
        .RX_data    (RX_data),
        .Empty      (Empty),
        .rd_uart_en (rd_uart_en),
        .Enable_rx  (Enable_rx),
        .Enable_tx  (Enable_tx)
    );

    // Strobe and handshake monitor, sampled mid-cycle
    always @(negedge Clk) begin
        if (wr_uart_en) begin
            wr_cnt++;
            tx_last = TX_data;
        end
        if (rd_uart_en) rd_cnt++;
        if (bus.bvalid && bus.bready) b_cnt++;
        if (bus.rvalid && bus.rready) r_cnt++;
    end

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int w_delay,
                             output bit ok, output logic [1:0] resp);
        bit aw_done, w_done, aw_hs, w_hs, got;
        ok = 0; aw_done = 0; w_done = 0; got = 0; resp = 2'bxx;
        @(posedge Clk); #1;
        bus.awaddr = addr; bus.awvalid = 1'b1;
        bus.wdata = data; bus.wstrb = strb; bus.wvalid = (w_delay == 0);
        for (int t = 0; t < 50 && !(aw_done && w_done); t++) begin
            @(negedge Clk);
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            @(posedge Clk); #1;
            if (aw_hs) begin bus.awvalid = 1'b0; aw_done = 1; end
            if (w_hs)  begin bus.wvalid = 1'b0;  w_done = 1;  end
            if (!w_done && !bus.wvalid && t + 1 >= w_delay) bus.wvalid = 1'b1;
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        if (aw_done && w_done) begin
            bus.bready = 1'b1;
            for (int t = 0; t < 50 && !got; t++) begin
                @(negedge Clk);
                if (bus.bvalid) begin resp = bus.bresp; got = 1; end
            end
            @(posedge Clk); #1;
            bus.bready = 1'b0;
            ok = got;
        end
    endtask

    task automatic axi_read(input logic [3:0] addr, input int hold, output bit ok,
                            output logic [31:0] data, output logic [1:0] resp,
                            output bit stable);
        bit hs, done, got;
        ok = 0; stable = 1; done = 0; got = 0; data = 'x; resp = 2'bxx;
        @(posedge Clk); #1;
        bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b0;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge Clk);
            hs = bus.arvalid && bus.arready;
            @(posedge Clk); #1;
            if (hs) begin bus.arvalid = 1'b0; done = 1; end
        end
        bus.arvalid = 1'b0;
        if (done) begin
            for (int t = 0; t < 50 && !got; t++) begin
                @(negedge Clk);
                if (bus.rvalid) begin data = bus.rdata; resp = bus.rresp; got = 1; end
            end
            if (got) begin
                for (int i = 0; i < hold; i++) begin
                    @(negedge Clk);
                    if (!bus.rvalid || bus.rdata !== data) stable = 0;
                end
                @(posedge Clk); #1;
                bus.rready = 1'b1;
                @(negedge Clk);
                if (!bus.rvalid) stable = 0;
                @(posedge Clk); #1;
                bus.rready = 1'b0;
                ok = 1;
            end
        end
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        #3;
        checks++;
        if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, wr_uart_en,
             rd_uart_en, Enable_rx, Enable_tx, bus.bresp, bus.rresp, bus.rdata, TX_data} !== '0) begin
            $display("FAIL reset_outputs: outputs not all zero during reset (rdata=%h TX_data=%h ready=%b%b%b)",
                     bus.rdata, TX_data, bus.awready, bus.wready, bus.arready);
        end else passed++;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Resetn = 1'b1;
        @(posedge Clk); #1;
        checks++;
        if ({bus.awready, bus.wready, bus.arready} !== 3'b111)
            $display("FAIL reset_ready_rise: got %b expected 111",
                     {bus.awready, bus.wready, bus.arready});
        else passed++;
    endtask

    task automatic test_control();
        bit ok, st; logic [1:0] br, rr; logic [31:0] d;
        axi_write(4'hC, 32'h0000_0003, 4'hF, 0, ok, br);
        checks++;
        if (!ok || br !== 2'b00) $display("FAIL ctrl_write: ok=%0d bresp=%b expected ok=1 bresp=00", ok, br);
        else passed++;
        checks++;
        if ({Enable_rx, Enable_tx} !== 2'b11)
            $display("FAIL ctrl_enables: got %b expected 11", {Enable_rx, Enable_tx});
        else passed++;
        axi_read(4'hC, 0, ok, d, rr, st);
        checks++;
        if (!ok || d !== 32'h0000_0003 || rr !== 2'b00)
            $display("FAIL ctrl_readback: ok=%0d rdata=%h rresp=%b expected 00000003/00", ok, d, rr);
        else passed++;
        axi_write(4'hC, 32'h0000_0000, 4'h0, 0, ok, br);
        checks++;
        if ({Enable_rx, Enable_tx} !== 2'b11)
            $display("FAIL ctrl_no_strobe_write: got %b expected 11", {Enable_rx, Enable_tx});
        else passed++;
    endtask

    task automatic test_tx_push();
        bit ok; logic [1:0] br; int w0, b0;
        w0 = wr_cnt; b0 = b_cnt;
        Full = 1'b0;
        axi_write(4'h4, 32'h0000_00A5, 4'hF, 2, ok, br);
        repeat (2) @(negedge Clk);
        checks++;
        if (!ok || br !== 2'b00) $display("FAIL tx_write_resp: ok=%0d bresp=%b expected ok=1 bresp=00", ok, br);
        else passed++;
        checks++;
        if (wr_cnt - w0 !== 1) $display("FAIL tx_push_count: got %0d expected 1", wr_cnt - w0);
        else passed++;
        checks++;
        if (tx_last !== 8'hA5) $display("FAIL tx_data: got %h expected a5", tx_last);
        else passed++;
        checks++;
        if (b_cnt - b0 !== 1) $display("FAIL tx_bvalid_count: got %0d expected 1", b_cnt - b0);
        else passed++;
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2; logic [1:0] br; int w0;
        w0 = wr_cnt;
        axi_write(4'h4, 32'h0000_00C1, 4'hF, 0, ok1, br);
        axi_write(4'h4, 32'h0000_00D2, 4'hF, 0, ok2, br);
        repeat (2) @(negedge Clk);
        checks++;
        if (!ok1 || !ok2 || wr_cnt - w0 !== 2 || tx_last !== 8'hD2)
            $display("FAIL b2b_push: pushes=%0d last=%h expected 2/d2", wr_cnt - w0, tx_last);
        else passed++;
    endtask

    task automatic test_tx_drop();
        bit ok, st; logic [1:0] br, rr; logic [31:0] d; int w0;
        w0 = wr_cnt;
        Full = 1'b1;
        axi_write(4'h4, 32'h0000_005A, 4'hF, 0, ok, br);
        Full = 1'b0;
        repeat (2) @(negedge Clk);
        checks++;
        if (!ok || wr_cnt - w0 !== 0) $display("FAIL drop_no_push: pushes=%0d expected 0", wr_cnt - w0);
        else passed++;
        axi_read(4'h8, 0, ok, d, rr, st);
        checks++;
        if (!ok || d !== 32'h0000_0004) $display("FAIL drop_status: got %h expected 00000004", d);
        else passed++;
        axi_write(4'h8, 32'h0000_0004, 4'hF, 0, ok, br);
        axi_read(4'h8, 0, ok, d, rr, st);
        checks++;
        if (!ok || d !== 32'h0000_0000) $display("FAIL drop_clear: got %h expected 00000000", d);
        else passed++;
    endtask

    task automatic test_rx_pop();
        bit ok, st; logic [1:0] rr; logic [31:0] d; int r0;
        r0 = rd_cnt;
        Empty = 1'b0; RX_data = 8'h3C;
        axi_read(4'h0, 5, ok, d, rr, st);
        Empty = 1'b1;
        checks++;
        if (!ok || d !== 32'h0000_013C || rr !== 2'b00)
            $display("FAIL rx_data: ok=%0d rdata=%h rresp=%b expected 0000013c/00", ok, d, rr);
        else passed++;
        checks++;
        if (!st) $display("FAIL rx_stable: rdata or rvalid changed while rready low, expected stable");
        else passed++;
        checks++;
        if (rd_cnt - r0 !== 1) $display("FAIL rx_pop_count: got %0d expected 1", rd_cnt - r0);
        else passed++;
        r0 = rd_cnt;
        RX_data = 8'h77;
        axi_read(4'h0, 0, ok, d, rr, st);
        checks++;
        if (!ok || d !== 32'h0 || rd_cnt - r0 !== 0)
            $display("FAIL rx_empty: rdata=%h pops=%0d expected 00000000/0", d, rd_cnt - r0);
        else passed++;
    endtask

    task automatic test_concurrent();
        bit okw, okr, st; logic [1:0] br, rr; logic [31:0] d; int b0, r0;
        b0 = b_cnt; r0 = r_cnt;
        Full = 1'b1;
        fork
            axi_write(4'hC, 32'h0000_0001, 4'hF, 0, okw, br);
            axi_read(4'h8, 0, okr, d, rr, st);
        join
        Full = 1'b0;
        repeat (2) @(negedge Clk);
        checks++;
        if (!okr || d !== 32'h0000_0002 || rr !== 2'b00)
            $display("FAIL conc_read: rdata=%h rresp=%b expected 00000002/00", d, rr);
        else passed++;
        checks++;
        if (!okw || br !== 2'b00 || {Enable_rx, Enable_tx} !== 2'b10)
            $display("FAIL conc_write: bresp=%b en=%b expected 00/10", br, {Enable_rx, Enable_tx});
        else passed++;
        checks++;
        if (b_cnt - b0 !== 1 || r_cnt - r0 !== 1)
            $display("FAIL conc_counts: b=%0d r=%0d expected 1/1", b_cnt - b0, r_cnt - r0);
        else passed++;
    endtask

    task automatic test_reset_mid_write();
        bit ok, st, got; logic [1:0] br, rr; logic [31:0] d; int w0, r0;
        Full = 1'b1;
        axi_write(4'h4, 32'h0000_0077, 4'hF, 0, ok, br);
        Full = 1'b0;
        axi_write(4'hC, 32'h0000_0003, 4'hF, 0, ok, br);
        @(posedge Clk); #1;
        bus.awaddr = 4'h4; bus.awvalid = 1'b1;
        bus.wdata = 32'h0000_0011; bus.wstrb = 4'hF; bus.wvalid = 1'b1; bus.bready = 1'b0;
        @(posedge Clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        got = 0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge Clk);
            if (bus.bvalid) got = 1;
        end
        checks++;
        if (!got) $display("FAIL mid_bvalid_timeout: bvalid=0 expected 1");
        else passed++;
        #1;
        w0 = wr_cnt; r0 = rd_cnt;
        Resetn = 1'b0;
        #1;
        checks++;
        if ({bus.bvalid, Enable_rx, Enable_tx, bus.awready} !== 4'b0000)
            $display("FAIL mid_reset_outputs: bvalid/en_rx/en_tx/awready=%b expected 0000",
                     {bus.bvalid, Enable_rx, Enable_tx, bus.awready});
        else passed++;
        repeat (2) @(negedge Clk);
        Resetn = 1'b1;
        repeat (5) @(negedge Clk);
        checks++;
        if (wr_cnt !== w0 || rd_cnt !== r0)
            $display("FAIL mid_no_strobe: pushes=%0d pops=%0d expected 0/0", wr_cnt - w0, rd_cnt - r0);
        else passed++;
        axi_read(4'h8, 0, ok, d, rr, st);
        checks++;
        if (!ok || d !== 32'h0) $display("FAIL mid_drop_cleared: status=%h expected 00000000", d);
        else passed++;
    endtask

    initial begin
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
        bus.wvalid = 1'b0; bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;
        #1;
        test_reset();
        test_control();
        test_tx_push();
        test_back_to_back();
        test_tx_drop();
        test_rx_pop();
        test_concurrent();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
